// File: rtl/lc3_decode_pkg.sv
// Shared LC-3 decode definitions: opcode enum, E_control field layout and
// pcselect1 / W_Control encodings, used by the decoder RTL and its bench.
`default_nettype none

package lc3_decode_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RSV  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } opcode_e;

  localparam int unsigned EC_WIDTH      = 6;
  localparam int unsigned EC_ALU_LSB    = 4;
  localparam int unsigned EC_PCSEL1_LSB = 2;
  localparam int unsigned EC_PCSEL2_BIT = 1;
  localparam int unsigned EC_OP2_BIT    = 0;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  localparam logic [1:0] PCSEL1_NONE = 2'b00;
  localparam logic [1:0] PCSEL1_OFF9 = 2'b01;
  localparam logic [1:0] PCSEL1_OFF6 = 2'b10;
  localparam logic [1:0] PCSEL1_ZERO = 2'b11;

  localparam logic [1:0] WSEL_ALU = 2'b00;
  localparam logic [1:0] WSEL_MEM = 2'b01;
  localparam logic [1:0] WSEL_PC  = 2'b10;

  function automatic logic [EC_WIDTH-1:0] pack_e_control(
    input logic [1:0] alu,
    input logic [1:0] pcsel1,
    input logic       pcsel2,
    input logic       op2sel
  );
    logic [EC_WIDTH-1:0] e;
    e = '0;
    e[EC_ALU_LSB +: 2]    = alu;
    e[EC_PCSEL1_LSB +: 2] = pcsel1;
    e[EC_PCSEL2_BIT]      = pcsel2;
    e[EC_OP2_BIT]         = op2sel;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lc3_decode_ctrl.sv
// Combinational opcode-to-control lookup for the LC-3 decode stage.
`default_nettype none

module lc3_decode_ctrl
  import lc3_decode_pkg::*;
(
  input  logic [3:0]          opcode_i,
  input  logic                imm_sel_i,
  output logic [EC_WIDTH-1:0] e_control_o,
  output logic                mem_control_o,
  output logic [1:0]          w_control_o
);

  opcode_e    op;
  logic [1:0] alu;
  logic [1:0] pcsel1;
  logic       pcsel2;
  logic       op2sel;

  assign op = opcode_e'(opcode_i);

  // Unsupported opcodes fall through to the all-zero defaults (NOP).
  always_comb begin
    alu           = ALU_ADD;
    pcsel1        = PCSEL1_NONE;
    pcsel2        = 1'b0;
    op2sel        = 1'b0;
    mem_control_o = 1'b0;
    w_control_o   = WSEL_ALU;
    case (op)
      OP_ADD: op2sel = ~imm_sel_i;
      OP_AND: begin
        alu    = ALU_AND;
        op2sel = ~imm_sel_i;
      end
      OP_NOT: begin
        alu    = ALU_NOT;
        op2sel = 1'b1;
      end
      OP_BR, OP_ST: begin
        pcsel1 = PCSEL1_OFF9;
        pcsel2 = 1'b1;
      end
      OP_LD: begin
        pcsel1      = PCSEL1_OFF9;
        pcsel2      = 1'b1;
        w_control_o = WSEL_MEM;
      end
      OP_LDI: begin
        pcsel1        = PCSEL1_OFF9;
        pcsel2        = 1'b1;
        mem_control_o = 1'b1;
        w_control_o   = WSEL_MEM;
      end
      OP_STI: begin
        pcsel1        = PCSEL1_OFF9;
        pcsel2        = 1'b1;
        mem_control_o = 1'b1;
      end
      OP_LEA: begin
        pcsel1      = PCSEL1_OFF9;
        pcsel2      = 1'b1;
        w_control_o = WSEL_PC;
      end
      OP_LDR: begin
        pcsel1      = PCSEL1_OFF6;
        w_control_o = WSEL_MEM;
      end
      OP_STR: pcsel1 = PCSEL1_OFF6;
      OP_JMP: pcsel1 = PCSEL1_ZERO;
      default: ;
    endcase
    e_control_o = pack_e_control(alu, pcsel1, pcsel2, op2sel);
  end

endmodule

`default_nettype wire

// File: rtl/lc3_decode.sv
// LC-3 decode stage: registers the instruction, NPC and decoded control
// fields on enabled clock edges; asynchronous active-low reset.
`default_nettype none

module lc3_decode
  import lc3_decode_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                enable_decode,
  input  logic [15:0]         instr_dout,
  input  logic [15:0]         npc_in,
  output logic [15:0]         IR,
  output logic [EC_WIDTH-1:0] E_control,
  output logic [15:0]         npc_out,
  output logic                Mem_Control,
  output logic [1:0]          W_Control
);

  logic [EC_WIDTH-1:0] ctrl_e;
  logic                ctrl_mem;
  logic [1:0]          ctrl_w;

  logic [15:0]         ir_d, ir_q;
  logic [EC_WIDTH-1:0] e_d, e_q;
  logic [15:0]         npc_d, npc_q;
  logic                mem_d, mem_q;
  logic [1:0]          w_d, w_q;

  lc3_decode_ctrl u_ctrl (
    .opcode_i      (instr_dout[15:12]),
    .imm_sel_i     (instr_dout[5]),
    .e_control_o   (ctrl_e),
    .mem_control_o (ctrl_mem),
    .w_control_o   (ctrl_w)
  );

  always_comb begin
    ir_d  = ir_q;
    e_d   = e_q;
    npc_d = npc_q;
    mem_d = mem_q;
    w_d   = w_q;
    if (enable_decode) begin
      ir_d  = instr_dout;
      e_d   = ctrl_e;
      npc_d = npc_in;
      mem_d = ctrl_mem;
      w_d   = ctrl_w;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir_q  <= '0;
      e_q   <= '0;
      npc_q <= '0;
      mem_q <= 1'b0;
      w_q   <= '0;
    end else begin
      ir_q  <= ir_d;
      e_q   <= e_d;
      npc_q <= npc_d;
      mem_q <= mem_d;
      w_q   <= w_d;
    end
  end

  assign IR          = ir_q;
  assign E_control   = e_q;
  assign npc_out     = npc_q;
  assign Mem_Control = mem_q;
  assign W_Control   = w_q;

endmodule

`default_nettype wire
